// File: rtl/morse_key_sequencer.sv
// Straight-key timer: classifies presses (dot/dash) and silences (interchar/interword), strobes each event; key edge to writing = 5 clk.
// One-entry slot with read_ack handshake; a post into a busy slot is dropped (sticky overrun). Build macro MORSE_SEQ_GLITCH_EN drops presses under MIN_PRESS ticks.
module morse_key_sequencer #(
  parameter int CNT_W     = 8,
  parameter int DOT_MAX   = 2,
  parameter int CHAR_GAP  = 3,
  parameter int WORD_GAP  = 7,
  parameter int ACK_TO    = 4,
  parameter int MIN_PRESS = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic key,
  input  logic tick,
  input  logic read_ack,
  output logic writing,
  output logic dot,
  output logic dash,
  output logic interchar,
  output logic interword,
  output logic busy,
  output logic overrun,
  output logic ack_err
);

  localparam int AW = $clog2(ACK_TO + 1);
`ifdef MORSE_SEQ_GLITCH_EN
  localparam bit GLITCH_EN = 1'b1;
`else
  localparam bit GLITCH_EN = 1'b0;
`endif

  typedef enum logic [1:0] {T_IDLE, T_PRESS, T_GAP} t_state_e;
  typedef enum logic [1:0] {I_EMPTY, I_ISSUE, I_WAIT} i_state_e;
  typedef enum logic [1:0] {EV_DOT, EV_DASH, EV_CHAR, EV_WORD} ev_e;

  logic             key_s1_q, key_s1_d, key_s2_q, key_s2_d, key_prev_q, key_prev_d;
  t_state_e         t_state_q, t_state_d;
  logic [CNT_W-1:0] press_cnt_q, press_cnt_d, gap_cnt_q, gap_cnt_d;
  logic             sym_seen_q, sym_seen_d, word_seen_q, word_seen_d;
  logic             from_gap_q, from_gap_d;
  logic             post_vld_q, post_vld_d;
  ev_e              post_code_q, post_code_d;
  logic             slot_full_q, slot_full_d;
  ev_e              slot_code_q, slot_code_d;
  i_state_e         i_state_q, i_state_d;
  logic [AW-1:0]    ack_cnt_q, ack_cnt_d;
  logic             overrun_q, overrun_d, ack_err_q, ack_err_d;
  logic             key_rise, key_fall, glitch, slot_free;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  assign key_rise = key_s2_q & ~key_prev_q;
  assign key_fall = ~key_s2_q & key_prev_q;
  assign glitch   = GLITCH_EN && (press_cnt_q < CNT_W'(MIN_PRESS));

  // Timing FSM: a tick arriving with a key edge is credited to the phase being entered.
  always_comb begin
    key_s1_d    = key;
    key_s2_d    = key_s1_q;
    key_prev_d  = key_s2_q;
    t_state_d   = t_state_q;
    press_cnt_d = press_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    sym_seen_d  = sym_seen_q;
    word_seen_d = word_seen_q;
    from_gap_d  = from_gap_q;
    post_vld_d  = 1'b0;
    post_code_d = post_code_q;
    case (t_state_q)
      T_IDLE: begin
        if (key_rise) begin
          t_state_d   = T_PRESS;
          press_cnt_d = tick ? CNT_W'(1) : '0;
          from_gap_d  = 1'b0;
        end
      end
      T_PRESS: begin
        if (key_fall) begin
          if (glitch) begin
            // Short press is ignored: resume the silence that preceded it.
            t_state_d = from_gap_q ? T_GAP : T_IDLE;
            if (from_gap_q && tick) gap_cnt_d = sat_inc(gap_cnt_q);
          end else begin
            t_state_d   = T_GAP;
            post_vld_d  = 1'b1;
            post_code_d = (press_cnt_q <= CNT_W'(DOT_MAX)) ? EV_DOT : EV_DASH;
            sym_seen_d  = 1'b1;
            word_seen_d = 1'b1;
            gap_cnt_d   = tick ? CNT_W'(1) : '0;
          end
        end else if (tick) begin
          press_cnt_d = sat_inc(press_cnt_q);
        end
      end
      T_GAP: begin
        if (key_rise) begin
          t_state_d   = T_PRESS;
          press_cnt_d = tick ? CNT_W'(1) : '0;
          from_gap_d  = 1'b1;
        end else if (tick) begin
          gap_cnt_d = sat_inc(gap_cnt_q);
          if (gap_cnt_d == CNT_W'(WORD_GAP) && word_seen_q) begin
            post_vld_d  = 1'b1;
            post_code_d = EV_WORD;
            word_seen_d = 1'b0;
            t_state_d   = T_IDLE;
          end else if (gap_cnt_d == CNT_W'(CHAR_GAP) && sym_seen_q) begin
            post_vld_d  = 1'b1;
            post_code_d = EV_CHAR;
            sym_seen_d  = 1'b0;
          end
        end
      end
      default: t_state_d = T_IDLE;
    endcase
  end

  // Slot and issue FSM: the slot empties on the ISSUE edge, so a post landing then is accepted.
  always_comb begin
    slot_full_d = slot_full_q;
    slot_code_d = slot_code_q;
    overrun_d   = overrun_q;
    ack_err_d   = ack_err_q;
    i_state_d   = i_state_q;
    ack_cnt_d   = ack_cnt_q;
    writing     = 1'b0;
    dot         = 1'b0;
    dash        = 1'b0;
    interchar   = 1'b0;
    interword   = 1'b0;
    busy        = 1'b0;
    slot_free   = (i_state_q == I_ISSUE);
    if (slot_free) slot_full_d = 1'b0;
    if (post_vld_q) begin
      if (!slot_full_q || slot_free) begin
        slot_full_d = 1'b1;
        slot_code_d = post_code_q;
      end else begin
        overrun_d = 1'b1;
      end
    end
    case (i_state_q)
      I_EMPTY: if (slot_full_q) i_state_d = I_ISSUE;
      I_ISSUE: begin
        writing   = 1'b1;
        dot       = (slot_code_q == EV_DOT);
        dash      = (slot_code_q == EV_DASH);
        interchar = (slot_code_q == EV_CHAR);
        interword = (slot_code_q == EV_WORD);
        i_state_d = I_WAIT;
        ack_cnt_d = '0;
      end
      I_WAIT: begin
        busy = 1'b1;
        if (read_ack) begin
          i_state_d = I_EMPTY;
          ack_cnt_d = '0;
        end else if (ack_cnt_q == AW'(ACK_TO - 1)) begin
          ack_err_d = 1'b1;
          i_state_d = I_EMPTY;
          ack_cnt_d = '0;
        end else begin
          ack_cnt_d = ack_cnt_q + 1'b1;
        end
      end
      default: i_state_d = I_EMPTY;
    endcase
  end

  assign overrun = overrun_q;
  assign ack_err = ack_err_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      key_s1_q    <= 1'b0;
      key_s2_q    <= 1'b0;
      key_prev_q  <= 1'b0;
      t_state_q   <= T_IDLE;
      press_cnt_q <= '0;
      gap_cnt_q   <= '0;
      sym_seen_q  <= 1'b0;
      word_seen_q <= 1'b0;
      from_gap_q  <= 1'b0;
      post_vld_q  <= 1'b0;
      post_code_q <= EV_DOT;
      slot_full_q <= 1'b0;
      slot_code_q <= EV_DOT;
      i_state_q   <= I_EMPTY;
      ack_cnt_q   <= '0;
      overrun_q   <= 1'b0;
      ack_err_q   <= 1'b0;
    end else begin
      key_s1_q    <= key_s1_d;
      key_s2_q    <= key_s2_d;
      key_prev_q  <= key_prev_d;
      t_state_q   <= t_state_d;
      press_cnt_q <= press_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      sym_seen_q  <= sym_seen_d;
      word_seen_q <= word_seen_d;
      from_gap_q  <= from_gap_d;
      post_vld_q  <= post_vld_d;
      post_code_q <= post_code_d;
      slot_full_q <= slot_full_d;
      slot_code_q <= slot_code_d;
      i_state_q   <= i_state_d;
      ack_cnt_q   <= ack_cnt_d;
      overrun_q   <= overrun_d;
      ack_err_q   <= ack_err_d;
    end
  end

endmodule

// File: tb/tb_morse_key_sequencer.sv
// Bench for morse_key_sequencer: directed scenarios plus random press/gap streams checked against an event-level model.
`timescale 1ns/1ps
module tb_morse_key_sequencer;
  logic clk = 1'b0;
  logic reset, key, tick, read_ack;
  logic writing, dot, dash, interchar, interword, busy, overrun, ack_err;

  morse_key_sequencer #(
    .CNT_W(8), .DOT_MAX(2), .CHAR_GAP(3), .WORD_GAP(7), .ACK_TO(4), .MIN_PRESS(1)
  ) dut (
    .clk(clk), .reset(reset), .key(key), .tick(tick), .read_ack(read_ack),
    .writing(writing), .dot(dot), .dash(dash), .interchar(interchar), .interword(interword),
    .busy(busy), .overrun(overrun), .ack_err(ack_err)
  );

  always #5 clk = ~clk;

  // Event codes: 0 dot, 1 dash, 2 interchar, 3 interword
  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int tphase = 0;
  int got_code[$];
  int got_cyc[$];
  int inv_bad = 0;
  int busy_cnt = 0;
  bit ack_en = 1'b1;
  bit saw_wr = 1'b0;
  bit prev_wr = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Decoder stand-in: acknowledges one clock after each strobe and records what was strobed.
  initial begin
    int nq;
    read_ack = 1'b0;
    forever begin
      @(posedge clk); #1;
      read_ack = ack_en && saw_wr;
      saw_wr = writing;
      if (busy === 1'b1) busy_cnt++;
      nq = int'(dot) + int'(dash) + int'(interchar) + int'(interword);
      if (writing === 1'b1) begin
        if (nq != 1 || prev_wr) inv_bad++;
        got_code.push_back(dot ? 0 : dash ? 1 : interchar ? 2 : 3);
        got_cyc.push_back(cyc);
      end else if (nq != 0) begin
        inv_bad++;
      end
      prev_wr = (writing === 1'b1);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk); #1;
    tphase = (tphase + 1) % 4;
    tick = (tphase == 0);
  endtask

  task automatic units(input int n);
    repeat (4 * n) step();
  endtask

  task automatic apply_reset();
    while (tphase != 0) step();
    reset = 1'b1; key = 1'b0; ack_en = 1'b1;
    units(1);
    reset = 1'b0;
    units(1);
    got_code.delete(); got_cyc.delete();
    busy_cnt = 0; inv_bad = 0;
  endtask

  task automatic press_gap(input int p, input int g);
    key = 1'b1; units(p);
    key = 1'b0; units(g);
  endtask

  task automatic test_reset();
    logic [7:0] outs;
    reset = 1'b1; key = 1'b0; tphase = 0; tick = 1'b1;
    repeat (3) step();
    outs = {writing, dot, dash, interchar, interword, busy, overrun, ack_err};
    for (int i = 0; i < 8; i++) begin
      vectors++;
      if (outs[i] !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_out[%0d]: got %b want 0", i, outs[i]);
      end
    end
    reset = 1'b0;
  endtask

  task automatic test_dot_char_word();
    int exp_q[$] = '{0, 2, 3};
    int act, rel;
    apply_reset();
    key = 1'b1; units(2);
    key = 1'b0; rel = cyc; units(10);
    vectors++;
    if (got_code.size() != exp_q.size()) begin
      miscompares++; $display("FAIL dcw_count: got %0d want %0d", got_code.size(), exp_q.size());
    end
    foreach (exp_q[i]) begin
      act = (i < got_code.size()) ? got_code[i] : -1;
      vectors++;
      if (act != exp_q[i]) begin
        miscompares++; $display("FAIL dcw_event[%0d]: got %0d want %0d", i, act, exp_q[i]);
      end
    end
    act = (got_cyc.size() > 0) ? got_cyc[0] - rel : -1;
    vectors++;
    if (act != 5) begin
      miscompares++; $display("FAIL dcw_latency: got %0d clk want 5", act);
    end
    vectors++;
    if (ack_err !== 1'b0 || inv_bad != 0) begin
      miscompares++; $display("FAIL dcw_flags: got ack_err=%b inv_bad=%0d want 0/0", ack_err, inv_bad);
    end
  endtask

  task automatic test_dash_dot();
    int exp_a[$] = '{1, 0, 2};
    int exp_q[$] = '{1, 0, 2, 0, 2, 3};
    int act;
    apply_reset();
    press_gap(3, 1);
    press_gap(1, 4);
    vectors++;
    if (got_code.size() != exp_a.size()) begin
      miscompares++; $display("FAIL dd_count_4tick: got %0d want %0d", got_code.size(), exp_a.size());
    end
    press_gap(1, 10);
    vectors++;
    if (got_code.size() != exp_q.size()) begin
      miscompares++; $display("FAIL dd_count: got %0d want %0d", got_code.size(), exp_q.size());
    end
    foreach (exp_q[i]) begin
      act = (i < got_code.size()) ? got_code[i] : -1;
      vectors++;
      if (act != exp_q[i]) begin
        miscompares++; $display("FAIL dd_event[%0d]: got %0d want %0d", i, act, exp_q[i]);
      end
    end
  endtask

  task automatic test_no_interchar();
    int exp_q[$] = '{0, 0, 2, 3};
    int act;
    apply_reset();
    press_gap(2, 2);
    press_gap(2, 10);
    vectors++;
    if (got_code.size() != exp_q.size()) begin
      miscompares++; $display("FAIL nic_count: got %0d want %0d", got_code.size(), exp_q.size());
    end
    foreach (exp_q[i]) begin
      act = (i < got_code.size()) ? got_code[i] : -1;
      vectors++;
      if (act != exp_q[i]) begin
        miscompares++; $display("FAIL nic_event[%0d]: got %0d want %0d", i, act, exp_q[i]);
      end
    end
  endtask

  task automatic test_ack_timeout();
    int exp_q[$] = '{0, 2, 3};
    int act;
    apply_reset();
    ack_en = 1'b0;
    press_gap(1, 3);
    vectors++;
    if (busy_cnt != 4 || ack_err !== 1'b1) begin
      miscompares++; $display("FAIL to_busy: got busy=%0d ack_err=%b want 4/1", busy_cnt, ack_err);
    end
    ack_en = 1'b1;
    units(8);
    vectors++;
    if (busy_cnt != 6 || ack_err !== 1'b1) begin
      miscompares++; $display("FAIL to_after: got busy=%0d ack_err=%b want 6/1", busy_cnt, ack_err);
    end
    foreach (exp_q[i]) begin
      act = (i < got_code.size()) ? got_code[i] : -1;
      vectors++;
      if (act != exp_q[i]) begin
        miscompares++; $display("FAIL to_event[%0d]: got %0d want %0d", i, act, exp_q[i]);
      end
    end
  endtask

  task automatic test_overrun();
    int exp_q[$] = '{0, 0, 2, 3};
    int act;
    apply_reset();
    ack_en = 1'b0;
    key = 1'b1; units(1);
    key = 1'b0; repeat (4) step();
    key = 1'b1; step();
    key = 1'b0; step();
    key = 1'b1; step();
    key = 1'b0; units(12);
    vectors++;
    if (overrun !== 1'b1 || ack_err !== 1'b1) begin
      miscompares++; $display("FAIL ov_flags: got overrun=%b ack_err=%b want 1/1", overrun, ack_err);
    end
    vectors++;
    if (got_code.size() != exp_q.size()) begin
      miscompares++; $display("FAIL ov_count: got %0d want %0d", got_code.size(), exp_q.size());
    end
    foreach (exp_q[i]) begin
      act = (i < got_code.size()) ? got_code[i] : -1;
      vectors++;
      if (act != exp_q[i]) begin
        miscompares++; $display("FAIL ov_event[%0d]: got %0d want %0d", i, act, exp_q[i]);
      end
    end
    reset = 1'b1; step();
    vectors++;
    if (overrun !== 1'b0 || ack_err !== 1'b0) begin
      miscompares++; $display("FAIL ov_sticky_clear: got overrun=%b ack_err=%b want 0/0", overrun, ack_err);
    end
    reset = 1'b0;
  endtask

  task automatic test_reset_mid_press();
    logic [7:0] outs;
    apply_reset();
    key = 1'b1; units(2);
    reset = 1'b1; step();
    outs = {writing, dot, dash, interchar, interword, busy, overrun, ack_err};
    vectors++;
    if (outs !== 8'h00) begin
      miscompares++; $display("FAIL rmp_outs: got %b want 00000000", outs);
    end
    key = 1'b0; reset = 1'b0;
    units(12);
    vectors++;
    if (got_code.size() != 0) begin
      miscompares++; $display("FAIL rmp_events: got %0d want 0", got_code.size());
    end
  endtask

  task automatic test_random();
    int exp_q[$];
    int p, g, act;
    apply_reset();
    for (int s = 0; s < 25; s++) begin
      p = int'($urandom_range(1, 5));
      g = (s == 24) ? 10 : int'($urandom_range(1, 9));
      exp_q.push_back(p <= 2 ? 0 : 1);
      if (g >= 3) exp_q.push_back(2);
      if (g >= 7) exp_q.push_back(3);
      press_gap(p, g);
    end
    vectors++;
    if (got_code.size() != exp_q.size()) begin
      miscompares++; $display("FAIL rnd_count: got %0d want %0d", got_code.size(), exp_q.size());
    end
    foreach (exp_q[i]) begin
      act = (i < got_code.size()) ? got_code[i] : -1;
      vectors++;
      if (act != exp_q[i]) begin
        miscompares++; $display("FAIL rnd_event[%0d]: got %0d want %0d", i, act, exp_q[i]);
      end
    end
    vectors++;
    if (ack_err !== 1'b0 || overrun !== 1'b0 || inv_bad != 0) begin
      miscompares++;
      $display("FAIL rnd_flags: got ack_err=%b overrun=%b inv_bad=%0d want 0/0/0", ack_err, overrun, inv_bad);
    end
  endtask

  initial begin
    reset = 1'b1; key = 1'b0; tick = 1'b1;
    test_reset();
    test_dot_char_word();
    test_dash_dot();
    test_no_interchar();
    test_ack_timeout();
    test_overrun();
    test_reset_mid_press();
    test_random();
    vectors++;
    if (inv_bad != 0) begin
      miscompares++; $display("FAIL strobe_shape: got %0d bad cycles want 0", inv_bad);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
